// File: rtl/fir_lpf_par.sv
// fir_lpf_par: time-multiplexed low-pass FIR filter.
//
// A sample accepted on the input handshake is written into a circular history
// buffer. The filter sum y[n] = sum c[k]*x[n-k] is then built over
// N = ceil(Taps/Lanes) cycles, Lanes products per cycle. The sum is rounded
// half up from Q1.(CoeffWidth-1), saturated to DataWidth bits and held on the
// output handshake until it is taken.
//
// Ports:
//   clk_i         single clock
//   rst_i         synchronous active-high reset (clears history and coefficients)
//   coeff_we_i    coefficient write strobe (honoured only in IDLE with no input handshake)
//   coeff_addr_i  coefficient index, writes at or above Taps are dropped
//   coeff_data_i  signed coefficient, Q1.(CoeffWidth-1)
//   in_data_i     signed input sample
//   in_valid_i    input sample valid
//   in_ready_o    high only while idle
//   out_data_o    signed filtered sample, stable while out_valid_o is high
//   out_valid_o   result valid
//   out_ready_i   result accepted
module fir_lpf_par #(
  parameter int Taps       = 16,
  parameter int Lanes      = 2,
  parameter int DataWidth  = 10,
  parameter int CoeffWidth = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         coeff_we_i,
  input  logic [$clog2(Taps)-1:0]      coeff_addr_i,
  input  logic signed [CoeffWidth-1:0] coeff_data_i,
  input  logic signed [DataWidth-1:0]  in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DataWidth-1:0]  out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  localparam int AW   = $clog2(Taps);
  localparam int N    = (Taps + Lanes - 1) / Lanes;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam int KW   = $clog2(Taps + Lanes) + 1;
  localparam int PW   = DataWidth + CoeffWidth;
  localparam int AccW = PW + $clog2(Taps);

  localparam logic [AW-1:0]          LAST_IDX  = AW'(Taps - 1);
  localparam logic [CNTW-1:0]        LAST_STEP = CNTW'(N - 1);
  localparam logic [KW-1:0]          TAPS_K    = KW'(Taps);
  localparam logic [KW-1:0]          LANES_K   = KW'(Lanes);
  localparam logic [AW:0]            TAPS_W    = (AW+1)'(Taps);
  localparam logic [AW:0]            LANES_W   = (AW+1)'(Lanes);
  localparam logic signed [AccW-1:0] RND       = AccW'(64'sd1 << (CoeffWidth - 2));
  localparam logic signed [AccW-1:0] SAT_MAX   = AccW'((64'sd1 << (DataWidth - 1)) - 64'sd1);
  localparam logic signed [AccW-1:0] SAT_MIN   = AccW'(-(64'sd1 << (DataWidth - 1)));

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t state_reg, state_next;

  logic signed [DataWidth-1:0]  hist_mem  [Taps];
  logic signed [CoeffWidth-1:0] coeff_mem [Taps];

  logic [AW-1:0]                ptr_reg;       // slot of the newest sample
  logic [AW-1:0]                base_reg;      // history slot read by lane 0 this step
  logic [KW-1:0]                k0_reg;        // tap index handled by lane 0 this step
  logic [CNTW-1:0]              cnt_reg;
  logic signed [AccW-1:0]       acc_reg;
  logic signed [DataWidth-1:0]  out_data_reg;

  logic                         in_hs;
  logic                         last_step;
  logic                         coeff_wr_ok;
  logic [AW-1:0]                ptr_inc;
  logic [AW:0]                  base_diff;
  logic [AW-1:0]                base_dec;
  logic signed [AccW-1:0]       psum [Lanes+1];
  logic signed [AccW-1:0]       acc_next;
  logic signed [AccW-1:0]       rounded;
  logic signed [AccW-1:0]       shifted;
  logic signed [DataWidth-1:0]  sat_val;

  assign in_hs       = (state_reg == IDLE) && in_valid_i;
  assign last_step   = (cnt_reg == LAST_STEP);
  assign coeff_wr_ok = (state_reg == IDLE) && !in_valid_i && coeff_we_i
                       && ({1'b0, coeff_addr_i} < TAPS_W);
  assign ptr_inc     = (ptr_reg == LAST_IDX) ? '0 : ptr_reg + 1'b1;

  // Modular decrement by Lanes: a borrow out of the extended subtraction
  // means we stepped below slot 0, so fold back by Taps. Works for any Taps.
  assign base_diff = {1'b0, base_reg} - LANES_W;
  assign base_dec  = base_diff[AW] ? AW'(base_diff + TAPS_W) : base_diff[AW-1:0];

  // Lane gi multiplies c[k0+gi] by x[n-(k0+gi)]; taps past the end add zero.
  assign psum[0] = acc_reg;
  generate
    for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
      localparam logic [AW:0]   LOFF = (AW+1)'(gi);
      localparam logic [KW-1:0] KOFF = KW'(gi);

      logic [KW-1:0]          tap_k;
      logic                   tap_ok;
      logic [AW:0]            sdiff;
      logic [AW-1:0]          sidx;
      logic [AW-1:0]          cidx;
      logic signed [PW-1:0]   prod;
      logic signed [AccW-1:0] term;

      assign tap_k   = k0_reg + KOFF;
      assign tap_ok  = tap_k < TAPS_K;
      assign sdiff   = {1'b0, base_reg} - LOFF;
      assign sidx    = sdiff[AW] ? AW'(sdiff + TAPS_W) : sdiff[AW-1:0];
      assign cidx    = tap_ok ? tap_k[AW-1:0] : '0;
      assign prod    = hist_mem[sidx] * coeff_mem[cidx];
      assign term    = tap_ok ? AccW'(prod) : AccW'(0);
      assign psum[gi+1] = psum[gi] + term;
    end
  endgenerate

  assign acc_next = psum[Lanes];
  assign rounded  = acc_next + RND;
  assign shifted  = rounded >>> (CoeffWidth - 1);

  always_comb begin
    sat_val = shifted[DataWidth-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DataWidth-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DataWidth-1:0];
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (in_valid_i)  state_next = RUN;
      RUN:     if (last_step)   state_next = OUT;
      OUT:     if (out_ready_i) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_reg)
      IDLE:    in_ready_o  = 1'b1;
      OUT:     out_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign out_data_o = out_data_reg;

  // Datapath: history, coefficients, accumulation and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Taps; i++) begin
        hist_mem[i]  <= '0;
        coeff_mem[i] <= '0;
      end
      ptr_reg      <= '0;
      base_reg     <= '0;
      k0_reg       <= '0;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      out_data_reg <= '0;
    end else begin
      if (in_hs) begin
        hist_mem[ptr_inc] <= in_data_i;
        ptr_reg           <= ptr_inc;
        base_reg          <= ptr_inc;
        k0_reg            <= '0;
        cnt_reg           <= '0;
        acc_reg           <= '0;
      end else if (coeff_wr_ok) begin
        coeff_mem[coeff_addr_i] <= coeff_data_i;
      end

      if (state_reg == RUN) begin
        acc_reg  <= acc_next;
        base_reg <= base_dec;
        k0_reg   <= k0_reg + LANES_K;
        cnt_reg  <= cnt_reg + 1'b1;
        if (last_step) begin
          out_data_reg <= sat_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_lpf_par.sv
// tb_fir_lpf_par: self-checking bench for fir_lpf_par (Taps=5, Lanes=2).
// Directed impulse/saturation/illegal-write/backpressure/reset cases plus
// randomized streams, all checked against a direct-form convolution model.
module tb_fir_lpf_par;

  localparam int TAPS  = 5;
  localparam int LANES = 2;
  localparam int DW    = 10;
  localparam int CW    = 10;
  localparam int NSTEP = (TAPS + LANES - 1) / LANES;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 coeff_we;
  logic [2:0]           coeff_addr;
  logic signed [CW-1:0] coeff_data;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: coefficients and history, hist[0] = newest sample
  int cm   [TAPS];
  int hist [TAPS];

  int imp_c   [TAPS] = '{256, 128, 64, 32, 16};
  int imp_exp [6]    = '{50, 25, 13, 6, 3, 0};

  fir_lpf_par #(
    .Taps(TAPS), .Lanes(LANES), .DataWidth(DW), .CoeffWidth(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .coeff_we_i(coeff_we),
    .coeff_addr_i(coeff_addr),
    .coeff_data_i(coeff_data),
    .in_data_i(in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .out_data_o(out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      cm[k]   = 0;
      hist[k] = 0;
    end
  endtask

  // Convolution with round-half-up and saturation, in plain integer arithmetic
  task automatic model_accept(input int x, output int y);
    longint acc;
    longint r;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(cm[k]) * longint'(hist[k]);
    r = (acc + (64'sd1 << (CW - 2))) >>> (CW - 1);
    if (r > 511) r = 511;
    if (r < -512) r = -512;
    y = int'(r);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
  endtask

  // Legal-intent write issued in IDLE; the model keeps it only if the address exists
  task automatic coeff_write(input int a, input int d);
    coeff_we   = 1'b1;
    coeff_addr = a[2:0];
    coeff_data = d[CW-1:0];
    @(negedge clk);
    coeff_we = 1'b0;
    if (a < TAPS) cm[a] = d;
  endtask

  // One transaction. hold = cycles of out_ready=0 in OUT.
  // cw_mode 1: coefficient write coincident with the input handshake.
  // cw_mode 2: coefficient write during RUN. Neither may take effect.
  task automatic send(input string tag, input int x, input int hold, input int cw_mode,
                      output int y);
    int  yexp;
    int  lat;
    bit  ir_low;
    bit  stable;
    in_data  = x[DW-1:0];
    in_valid = 1'b1;
    if (cw_mode == 1) begin
      coeff_we   = 1'b1;
      coeff_addr = 3'd0;
      coeff_data = -10'sd7;
    end
    check_eq({tag, "_ready"}, int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    coeff_we = 1'b0;
    model_accept(x, yexp);
    if (cw_mode == 2) begin
      coeff_we   = 1'b1;
      coeff_addr = 3'd1;
      coeff_data = 10'sd200;
    end
    lat    = 0;
    ir_low = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) coeff_we = 1'b0;
      if (in_ready) ir_low = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    coeff_we = 1'b0;
    check_eq({tag, "_latency"}, lat, NSTEP + 1);
    check_eq({tag, "_busy"}, int'(ir_low), 1);
    y = int'(out_data);
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = ~x[DW-1:0];
      stable    = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (int'(out_data) != y || !out_valid || in_ready) stable = 1'b0;
      end
      check_eq({tag, "_hold"}, int'(stable), 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_drop"}, int'(out_valid), 0);
    check_eq({tag, "_out"}, y, yexp);
    $display("tx %s in=%0d out=%0d exp=%0d lat=%0d", tag, x, y, yexp, lat);
  endtask

  // Continuous input stream; optional random output backpressure
  task automatic stream(input int count, input bit rand_bp);
    int exp_q [$];
    int got_q [$];
    int hs_q  [$];
    int nacc;
    int yv;
    int r;
    bit pending;
    nacc    = 0;
    pending = 1'b0;
    r        = int'($urandom_range(0, 1023));
    in_data  = r[DW-1:0];
    in_valid = 1'b1;
    for (int budget = 0; budget < count * 40 + 50 && got_q.size() < count; budget++) begin
      if (pending) begin
        pending = 1'b0;
        if (nacc < count) begin
          r       = int'($urandom_range(0, 1023));
          in_data = r[DW-1:0];
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) got_q.push_back(int'(out_data));
      if (in_valid && in_ready) begin
        model_accept(int'(in_data), yv);
        exp_q.push_back(yv);
        hs_q.push_back(cyc);
        nacc++;
        pending = 1'b1;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("stream_count", got_q.size(), count);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq("stream_out", got_q[i], exp_q[i]);
      $display("tx stream%0d out=%0d exp=%0d", i, got_q[i], exp_q[i]);
    end
    if (!rand_bp) begin
      for (int i = 1; i < hs_q.size(); i++) begin
        check_eq("throughput", hs_q[i] - hs_q[i-1], NSTEP + 2);
      end
    end
  endtask

  initial begin
    int y;
    bit saw;
    rst        = 1'b1;
    coeff_we   = 1'b0;
    coeff_addr = '0;
    coeff_data = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_valid", int'(out_valid), 0);
    check_eq("reset_data", int'(out_data), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", int'(in_ready), 1);

    // Coefficients come out of reset as zero
    send("zero_coeff", 37, 0, 0, y);
    check_eq("zero_coeff_const", y, 0);

    // Impulse response
    reset_dut();
    for (int k = 0; k < TAPS; k++) coeff_write(k, imp_c[k]);
    for (int i = 0; i < 6; i++) begin
      send("imp", (i == 0) ? 100 : 0, 0, 0, y);
      check_eq("imp_const", y, imp_exp[i]);
    end

    // Saturation, both rails
    for (int k = 0; k < TAPS; k++) coeff_write(k, 511);
    for (int i = 0; i < 5; i++) send("satp", 511, 0, 0, y);
    check_eq("sat_pos_const", y, 511);
    for (int i = 0; i < 5; i++) send("satn", -512, 0, 0, y);
    check_eq("sat_neg_const", y, -512);

    // Illegal writes: bad address, coincident with handshake, during RUN
    reset_dut();
    for (int k = 0; k < TAPS; k++) coeff_write(k, imp_c[k]);
    coeff_write(6, 300);
    for (int i = 0; i < 6; i++) begin
      send("illegal", (i == 0) ? 100 : 0, 0, (i == 0) ? 1 : ((i == 1) ? 2 : 0), y);
      check_eq("illegal_const", y, imp_exp[i]);
    end

    // Backpressure: 10 cycles of out_ready=0 with a competing input pending
    send("bp", 37, 10, 0, y);
    send("bp_next", -90, 0, 0, y);

    // Reset in the middle of RUN abandons the computation
    send("pre_rst", 77, 0, 0, y);
    in_data  = 10'sd55;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check_eq("midrun_no_out", int'(saw), 0);
    check_eq("midrun_ready", int'(in_ready), 1);
    for (int k = 0; k < TAPS; k++) coeff_write(k, imp_c[k]);
    send("post_rst", 100, 0, 0, y);
    check_eq("post_rst_const", y, 50);

    // Random coefficients (some writes out of range) and random streams
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      coeff_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)) - 512);
    end
    stream(15, 1'b0);
    stream(15, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_lpf_par.md
FIR_LPF_PAR -- requirements
Module: fir_lpf_par

Interface
REQ-001 The block SHALL have the parameter Taps, default 16, meaning the number of filter taps (>=2).
REQ-002 The block SHALL have the parameter Lanes, default 2, meaning multiplications per cycle (1..Taps).
REQ-003 The block SHALL have the parameter DataWidth, default 10, meaning the signed sample width.
REQ-004 The block SHALL have the parameter CoeffWidth, default 10, meaning the signed coefficient width (Q1.(CoeffWidth-1)).
REQ-005 The block SHALL have the port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have the port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have the port coeff_we_i, input, 1 bit: coefficient write strobe.
REQ-008 The block SHALL have the port coeff_addr_i, input, $clog2(Taps) bits: coefficient index.
REQ-009 The block SHALL have the port coeff_data_i, input, CoeffWidth bits: signed coefficient.
REQ-010 The block SHALL have the port in_data_i, input, DataWidth bits: signed sample.
REQ-011 The block SHALL have the ports in_valid_i (input, 1 bit) and in_ready_o (output, 1 bit): the sample handshake.
REQ-012 The block SHALL have the port out_data_o, output, DataWidth bits: signed filtered sample.
REQ-013 The block SHALL have the ports out_valid_o (output, 1 bit) and out_ready_i (input, 1 bit): the result handshake.

Function
REQ-014 The block SHALL implement y[n] = sum over k=0..Taps-1 of c[k]*x[n-k], with a circular history buffer of Taps samples.
REQ-015 The block SHALL use the FSM states IDLE, RUN and OUT.
REQ-016 In IDLE, in_ready_o SHALL be 1; an in_valid_i&in_ready_o edge SHALL write the sample to the buffer, clear the accumulator and enter RUN.
REQ-017 RUN SHALL last exactly N = ceil(Taps/Lanes) cycles; each cycle SHALL consume tap indices j*Lanes..j*Lanes+Lanes-1, with lanes whose index is >= Taps contributing 0.
REQ-018 After RUN the block SHALL enter OUT, with out_valid_o=1 exactly N+1 cycles after the input handshake edge.
REQ-019 In OUT, out_data_o and out_valid_o SHALL hold stable until out_ready_i=1; the handshake edge SHALL return the FSM to IDLE.
REQ-020 in_ready_o SHALL be 0 in RUN and OUT; with out_ready_i tied 1, throughput SHALL be one sample per N+2 cycles.
REQ-021 Sample buffer index arithmetic SHALL wrap modulo Taps for any Taps, including values that are not a power of two.
REQ-022 The accumulator SHALL be full precision: DataWidth+CoeffWidth+$clog2(Taps) bits, signed.
REQ-023 The output SHALL be computed as the accumulator plus 2^(CoeffWidth-2), arithmetic-shifted right by CoeffWidth-1 (round half up).
REQ-024 The shifted result SHALL saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
REQ-025 A coeff_we_i write SHALL take effect only in IDLE when no input handshake occurs in the same cycle; otherwise the write SHALL be ignored.
REQ-026 Coefficient writes to addresses >= Taps SHALL be ignored.

Reset
REQ-027 While rst_i=1 at a clk_i edge, the block SHALL set the FSM to IDLE, zero the history buffer, accumulator and buffer pointer, and zero all coefficients.
REQ-028 On that same edge, out_valid_o SHALL be 0, out_data_o SHALL be 0, and in_ready_o SHALL be 1 from the first cycle after reset release.
REQ-029 A reset asserted during RUN or OUT SHALL abandon the computation without producing any output.

Verification (Taps=5, Lanes=2, DataWidth=10, CoeffWidth=10, so N=3)
REQ-030 Impulse: write c = 256,128,64,32,16, then feed 100,0,0,0,0,0 -> outputs 50,25,13,6,3,0.
REQ-031 Latency: a handshake at edge t -> out_valid_o rises at edge t+4, and in_ready_o is 0 over edges t+1..t+4.
REQ-032 Saturation: all c=511 and five inputs of 511 -> 5th output 511; all c=511 and five inputs of -512 -> 5th output -512.
REQ-033 Backpressure: out_ready_i=0 for 10 cycles in OUT -> out_data_o stable, in_ready_o=0, and the next input is accepted only after the output handshake.
REQ-034 Illegal writes: a coeff write during RUN, at address 6, or coincident with an input handshake -> coefficients unchanged, and the impulse response matches REQ-030.
REQ-035 Reset mid-RUN: rst_i pulsed at RUN cycle 2 -> no out_valid_o; a following impulse of 100 -> 50 (history cleared).
